// File: rtl/rfid_cmd_dispatch.sv
// rfid_cmd_dispatch: one-deep queued command scheduler between frame parser and handlers.
// Define RFID_CMD_TIMEOUT_EN to build the handler timeout (code 0xE2).
module rfid_cmd_dispatch #(
   parameter int MAX_LEN     = 32,
   parameter int N_HND       = 4,
   parameter int TIMEOUT_CYC = 1000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 pkt_ready,
   input  logic                 pkt_bad,
   input  logic [7:0]           pkt_type,
   input  logic [7:0]           pkt_len,
   input  logic [8*MAX_LEN-1:0] payload_bus,
   output logic [N_HND-1:0]     cmd_req,
   output logic [7:0]           cmd_len,
   output logic [8*MAX_LEN-1:0] cmd_payload,
   input  logic [N_HND-1:0]     hnd_done,
   input  logic [N_HND-1:0]     hnd_err,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [7:0]           rsp_type,
   output logic [7:0]           rsp_code,
   output logic                 busy,
   output logic [7:0]           drop_cnt,
   output logic [7:0]           bad_cnt
);

   localparam int PW = 8*MAX_LEN;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t         state_q;
   logic [7:0]     act_type_q;
   logic           pend_vld_q;
   logic [7:0]     pend_type_q;
   logic [7:0]     pend_len_q;
   logic [PW-1:0]  pend_pay_q;

   logic [7:0]     act_type_d;
   logic [7:0]     act_len_d;
   logic [PW-1:0]  act_pay_d;
   logic [N_HND-1:0] act_oh_d;
   logic           take;
   logic           done_hit;
   logic           err_hit;
   logic           tmo_hit;

   function automatic logic [N_HND-1:0] sel_oh(input logic [7:0] t);
      sel_oh = '0;
      for (int i = 0; i < N_HND; i++)
         if (t == 8'(i + 1)) sel_oh[i] = 1'b1;
   endfunction

   // The pending slot always has priority over a newly arriving packet.
   always_comb begin
      take       = pend_vld_q | pkt_ready;
      act_type_d = pend_vld_q ? pend_type_q : pkt_type;
      act_len_d  = pend_vld_q ? pend_len_q : pkt_len;
      act_pay_d  = pend_vld_q ? pend_pay_q : payload_bus;
      act_oh_d   = sel_oh(act_type_d);
   end

   assign done_hit = |(hnd_done & cmd_req);
   assign err_hit  = |(hnd_err & cmd_req);
   assign busy     = (state_q != IDLE);

`ifdef RFID_CMD_TIMEOUT_EN
   logic [15:0] tmo_q;

   assign tmo_hit = (tmo_q == 16'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         tmo_q <= '0;
      else if (state_q != WAIT)
         tmo_q <= '0;
      else
         tmo_q <= tmo_q + 16'd1;
   end
`else
   logic unused_tmo;

   assign tmo_hit    = 1'b0;
   assign unused_tmo = ^TIMEOUT_CYC;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         act_type_q  <= '0;
         pend_vld_q  <= 1'b0;
         pend_type_q <= '0;
         pend_len_q  <= '0;
         pend_pay_q  <= '0;
         cmd_req     <= '0;
         cmd_len     <= '0;
         cmd_payload <= '0;
         rsp_valid   <= 1'b0;
         rsp_type    <= '0;
         rsp_code    <= '0;
         drop_cnt    <= '0;
         bad_cnt     <= '0;
      end else begin
         if (pkt_bad && bad_cnt != 8'hFF)
            bad_cnt <= bad_cnt + 8'd1;

         unique case (state_q)
            IDLE: begin
               if (take) begin
                  act_type_q  <= act_type_d;
                  cmd_len     <= act_len_d;
                  cmd_payload <= act_pay_d;
                  pend_vld_q  <= pend_vld_q & pkt_ready;
                  if (pend_vld_q && pkt_ready) begin
                     pend_type_q <= pkt_type;
                     pend_len_q  <= pkt_len;
                     pend_pay_q  <= payload_bus;
                  end
                  if (act_oh_d != '0) begin
                     cmd_req <= act_oh_d;
                     state_q <= WAIT;
                  end else begin
                     rsp_valid <= 1'b1;
                     rsp_type  <= act_type_d | 8'h80;
                     rsp_code  <= 8'hE3;
                     state_q   <= RESP;
                  end
               end
            end
            WAIT: begin
               if (err_hit || done_hit || tmo_hit) begin
                  cmd_req   <= '0;
                  rsp_valid <= 1'b1;
                  rsp_type  <= act_type_q | 8'h80;
                  rsp_code  <= err_hit  ? 8'hE1 :
                               done_hit ? 8'h00 : 8'hE2;
                  state_q   <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (state_q != IDLE && pkt_ready) begin
            if (!pend_vld_q) begin
               pend_vld_q  <= 1'b1;
               pend_type_q <= pkt_type;
               pend_len_q  <= pkt_len;
               pend_pay_q  <= payload_bus;
            end else if (drop_cnt != 8'hFF) begin
               drop_cnt <= drop_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_rfid_cmd_dispatch.sv
// tb_rfid_cmd_dispatch: directed scenarios plus randomized traffic against a queue model.
// Define RFID_CMD_TIMEOUT_EN to exercise the timeout path.
module tb_rfid_cmd_dispatch;

   localparam int MAX_LEN = 32;
   localparam int N_HND   = 4;
   localparam int TMO     = 8;
   localparam int PW      = 8*MAX_LEN;

   typedef struct {
      logic [7:0]    t;
      logic [7:0]    len;
      logic [PW-1:0] pay;
   } pkt_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             pkt_ready = 1'b0;
   logic             pkt_bad = 1'b0;
   logic [7:0]       pkt_type = '0;
   logic [7:0]       pkt_len = '0;
   logic [PW-1:0]    payload_bus = '0;
   logic [N_HND-1:0] cmd_req;
   logic [7:0]       cmd_len;
   logic [PW-1:0]    cmd_payload;
   logic [N_HND-1:0] hnd_done = '0;
   logic [N_HND-1:0] hnd_err = '0;
   logic             rsp_valid;
   logic             rsp_ready = 1'b0;
   logic [7:0]       rsp_type;
   logic [7:0]       rsp_code;
   logic             busy;
   logic [7:0]       drop_cnt;
   logic [7:0]       bad_cnt;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   rfid_cmd_dispatch #(
      .MAX_LEN    (MAX_LEN),
      .N_HND      (N_HND),
      .TIMEOUT_CYC(TMO)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .pkt_ready  (pkt_ready),
      .pkt_bad    (pkt_bad),
      .pkt_type   (pkt_type),
      .pkt_len    (pkt_len),
      .payload_bus(payload_bus),
      .cmd_req    (cmd_req),
      .cmd_len    (cmd_len),
      .cmd_payload(cmd_payload),
      .hnd_done   (hnd_done),
      .hnd_err    (hnd_err),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_type   (rsp_type),
      .rsp_code   (rsp_code),
      .busy       (busy),
      .drop_cnt   (drop_cnt),
      .bad_cnt    (bad_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      pkt_ready = 1'b0;
      pkt_bad   = 1'b0;
      hnd_done  = '0;
      hnd_err   = '0;
      rsp_ready = 1'b0;
   endtask

   task automatic drive(input pkt_t p);
      pkt_ready   = 1'b1;
      pkt_type    = p.t;
      pkt_len     = p.len;
      payload_bus = p.pay;
   endtask

   task automatic do_reset();
      clear_in();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
   endtask

   function automatic pkt_t rnd_pkt();
      pkt_t p;
      p.t   = 8'($urandom_range(0, 6));
      p.len = 8'($urandom_range(1, MAX_LEN));
      for (int i = 0; i < PW/32; i++) p.pay[i*32 +: 32] = $urandom;
      return p;
   endfunction

   function automatic pkt_t mk_pkt(input logic [7:0] t, input logic [7:0] len);
      pkt_t p;
      p.t   = t;
      p.len = len;
      for (int i = 0; i < PW/32; i++) p.pay[i*32 +: 32] = $urandom;
      return p;
   endfunction

   task automatic test_reset();
      do_reset();
      n_chk++; if (cmd_req !== 4'b0) begin n_fail++; $display("FAIL rst_req: got %b want 0", cmd_req); end
      n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_chk++; if (cmd_len !== 8'h0 || rsp_type !== 8'h0 || rsp_code !== 8'h0) begin
         n_fail++; $display("FAIL rst_regs: len %h type %h code %h want 0", cmd_len, rsp_type, rsp_code); end
      n_chk++; if (cmd_payload !== '0) begin n_fail++; $display("FAIL rst_payload: got %h want 0", cmd_payload); end
      n_chk++; if (drop_cnt !== 8'h0 || bad_cnt !== 8'h0) begin
         n_fail++; $display("FAIL rst_cnt: drop %h bad %h want 0", drop_cnt, bad_cnt); end
   endtask

   task automatic test_known();
      pkt_t p;
      logic [PW-1:0] pl;
      pl = '0;
      pl[PW-1 -: 24] = 24'h112233;
      p.t = 8'h02; p.len = 8'd3; p.pay = pl;
      drive(p); tick(); clear_in();
      n_chk++; if (cmd_req !== 4'b0010) begin n_fail++; $display("FAIL known_req: got %b want 0010", cmd_req); end
      n_chk++; if (cmd_len !== 8'd3) begin n_fail++; $display("FAIL known_len: got %0d want 3", cmd_len); end
      n_chk++; if (cmd_payload !== pl) begin n_fail++; $display("FAIL known_pay: got %h want %h", cmd_payload, pl); end
      n_chk++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL known_busy: busy %b rsp %b want 1 0", busy, rsp_valid); end
      repeat (4) tick();
      n_chk++; if (cmd_req !== 4'b0010) begin n_fail++; $display("FAIL known_hold: got %b want 0010", cmd_req); end
      hnd_done = 4'b0010; tick(); clear_in();
      n_chk++; if (cmd_req !== 4'b0 || rsp_valid !== 1'b1) begin
         n_fail++; $display("FAIL known_done: req %b rsp %b want 0 1", cmd_req, rsp_valid); end
      n_chk++; if (rsp_type !== 8'h82 || rsp_code !== 8'h00) begin
         n_fail++; $display("FAIL known_rsp: type %h code %h want 82 00", rsp_type, rsp_code); end
      tick();
      n_chk++; if (rsp_valid !== 1'b1 || rsp_type !== 8'h82 || rsp_code !== 8'h00) begin
         n_fail++; $display("FAIL known_stable: v %b type %h code %h want 1 82 00", rsp_valid, rsp_type, rsp_code); end
      rsp_ready = 1'b1; tick(); clear_in();
      n_chk++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL known_idle: rsp %b busy %b want 0 0", rsp_valid, busy); end
   endtask

   task automatic test_unknown();
      pkt_t p;
      logic [7:0] tv [2];
      tv[0] = 8'h07;
      tv[1] = 8'h00;
      for (int i = 0; i < 2; i++) begin
         p = mk_pkt(tv[i], 8'd4);
         drive(p); tick(); clear_in();
         n_chk++; if (cmd_req !== 4'b0 || rsp_valid !== 1'b1) begin
            n_fail++; $display("FAIL unk_%0h: req %b rsp %b want 0 1", tv[i], cmd_req, rsp_valid); end
         n_chk++; if (rsp_type !== (tv[i] | 8'h80) || rsp_code !== 8'hE3) begin
            n_fail++; $display("FAIL unk_rsp_%0h: type %h code %h want %h E3", tv[i], rsp_type, rsp_code, tv[i] | 8'h80); end
         rsp_ready = 1'b1; tick(); clear_in();
      end
   endtask

   task automatic test_err_priority();
      drive(mk_pkt(8'h02, 8'd5)); tick(); clear_in();
      hnd_done = 4'b0001; hnd_err = 4'b0100; tick(); clear_in();
      n_chk++; if (cmd_req !== 4'b0010 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL err_ignore: req %b rsp %b want 0010 0", cmd_req, rsp_valid); end
      hnd_done = 4'b0010; hnd_err = 4'b0010; tick(); clear_in();
      n_chk++; if (rsp_valid !== 1'b1 || rsp_code !== 8'hE1 || rsp_type !== 8'h82) begin
         n_fail++; $display("FAIL err_win: v %b code %h type %h want 1 E1 82", rsp_valid, rsp_code, rsp_type); end
      rsp_ready = 1'b1; tick(); clear_in();
   endtask

   task automatic test_queue();
      pkt_t p3;
      do_reset();
      drive(mk_pkt(8'h01, 8'd2)); tick(); clear_in();
      p3 = mk_pkt(8'h03, 8'd9);
      drive(p3); tick(); clear_in();
      drive(mk_pkt(8'h04, 8'd1)); tick(); clear_in();
      drive(mk_pkt(8'h02, 8'd7)); tick(); clear_in();
      n_chk++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL q_drop: got %0d want 2", drop_cnt); end
      n_chk++; if (cmd_req !== 4'b0001) begin n_fail++; $display("FAIL q_active: got %b want 0001", cmd_req); end
      hnd_done = 4'b0001; tick(); clear_in();
      n_chk++; if (rsp_type !== 8'h81 || rsp_code !== 8'h00) begin
         n_fail++; $display("FAIL q_rsp: type %h code %h want 81 00", rsp_type, rsp_code); end
      rsp_ready = 1'b1; tick(); clear_in();
      n_chk++; if (busy !== 1'b0 || cmd_req !== 4'b0) begin
         n_fail++; $display("FAIL q_idle: busy %b req %b want 0 0", busy, cmd_req); end
      tick();
      n_chk++; if (cmd_req !== 4'b0100 || cmd_len !== p3.len || cmd_payload !== p3.pay) begin
         n_fail++; $display("FAIL q_pend: req %b len %0d want 0100 %0d", cmd_req, cmd_len, p3.len); end
      hnd_done = 4'b0100; tick(); clear_in();
      rsp_ready = 1'b1; tick(); clear_in();
      tick();
      n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL q_empty: busy %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      pkt_t pc;
      do_reset();
      drive(mk_pkt(8'h02, 8'd3)); tick(); clear_in();
      drive(mk_pkt(8'h04, 8'd6)); tick(); clear_in();
      hnd_done = 4'b0010; tick(); clear_in();
      rsp_ready = 1'b1; tick(); clear_in();
      pc = mk_pkt(8'h01, 8'd11);
      drive(pc); tick(); clear_in();
      n_chk++; if (cmd_req !== 4'b1000 || drop_cnt !== 8'd0) begin
         n_fail++; $display("FAIL b2b_promote: req %b drop %0d want 1000 0", cmd_req, drop_cnt); end
      hnd_done = 4'b1000; tick(); clear_in();
      n_chk++; if (rsp_valid !== 1'b1 || rsp_type !== 8'h84) begin
         n_fail++; $display("FAIL b2b_rsp: v %b type %h want 1 84", rsp_valid, rsp_type); end
      rsp_ready = 1'b1; tick(); clear_in();
      tick();
      n_chk++; if (cmd_req !== 4'b0001 || cmd_len !== pc.len || cmd_payload !== pc.pay) begin
         n_fail++; $display("FAIL b2b_refill: req %b len %0d want 0001 %0d", cmd_req, cmd_len, pc.len); end
      hnd_done = 4'b0001; tick(); clear_in();
      rsp_ready = 1'b1; tick(); clear_in();
   endtask

   task automatic test_timeout();
      do_reset();
      drive(mk_pkt(8'h03, 8'd2)); tick(); clear_in();
`ifdef RFID_CMD_TIMEOUT_EN
      repeat (TMO - 1) tick();
      n_chk++; if (cmd_req !== 4'b0100 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL tmo_early: req %b rsp %b want 0100 0", cmd_req, rsp_valid); end
      tick();
      n_chk++; if (cmd_req !== 4'b0 || rsp_valid !== 1'b1 || rsp_code !== 8'hE2 || rsp_type !== 8'h83) begin
         n_fail++; $display("FAIL tmo_fire: req %b v %b code %h type %h want 0 1 E2 83", cmd_req, rsp_valid, rsp_code, rsp_type); end
      hnd_done = 4'b0100; tick(); clear_in();
      n_chk++; if (rsp_valid !== 1'b1 || rsp_code !== 8'hE2) begin
         n_fail++; $display("FAIL tmo_late: v %b code %h want 1 E2", rsp_valid, rsp_code); end
      rsp_ready = 1'b1; tick(); clear_in();
      tick();
      n_chk++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL tmo_idle: v %b busy %b want 0 0", rsp_valid, busy); end
`else
      repeat (3*TMO) tick();
      n_chk++; if (cmd_req !== 4'b0100 || rsp_valid !== 1'b0) begin
         n_fail++; $display("FAIL notmo_hold: req %b rsp %b want 0100 0", cmd_req, rsp_valid); end
      hnd_done = 4'b0100; tick(); clear_in();
      n_chk++; if (rsp_valid !== 1'b1 || rsp_code !== 8'h00) begin
         n_fail++; $display("FAIL notmo_done: v %b code %h want 1 00", rsp_valid, rsp_code); end
      rsp_ready = 1'b1; tick(); clear_in();
`endif
   endtask

   task automatic test_bad_cnt();
      do_reset();
      pkt_bad = 1'b1;
      repeat (100) tick();
      n_chk++; if (bad_cnt !== 8'd100) begin n_fail++; $display("FAIL bad_100: got %0d want 100", bad_cnt); end
      repeat (200) tick();
      pkt_bad = 1'b0;
      n_chk++; if (bad_cnt !== 8'hFF) begin n_fail++; $display("FAIL bad_sat: got %h want FF", bad_cnt); end
      n_chk++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL bad_norsp: v %b busy %b want 0 0", rsp_valid, busy); end
   endtask

   task automatic test_random();
      pkt_t q[$];
      pkt_t p;
      pkt_t n;
      int drops;
      int iter;
      int oc;
      logic [3:0] oh;
      logic [7:0] code;
      do_reset();
      drops = 0;
      iter  = 0;
      while (iter < 40 || q.size() != 0) begin
         if (q.size() == 0) begin
            p = rnd_pkt();
            q.push_back(p);
            drive(p); tick(); clear_in();
         end else begin
            tick();
         end
         p  = q[0];
         oh = (p.t >= 1 && p.t <= N_HND) ? 4'(1 << (p.t - 1)) : 4'b0;
         if (oh != 4'b0) begin
            n_chk++; if (cmd_req !== oh || cmd_len !== p.len || cmd_payload !== p.pay) begin
               n_fail++; $display("FAIL rnd_disp %0d: req %b len %0d want %b %0d", iter, cmd_req, cmd_len, oh, p.len); end
            repeat ($urandom_range(0, 3)) begin
               hnd_done = 4'($urandom) & ~oh;
               hnd_err  = 4'($urandom) & ~oh;
               if (iter < 40 && $urandom_range(0, 2) == 0) begin
                  n = rnd_pkt();
                  drive(n);
                  if (q.size() < 2) q.push_back(n);
                  else if (drops < 255) drops++;
               end
               tick(); clear_in();
            end
            oc = $urandom_range(0, 2);
            hnd_done = (oc != 1 ? oh : 4'b0) | (4'($urandom) & ~oh);
            hnd_err  = (oc != 0 ? oh : 4'b0) | (4'($urandom) & ~oh);
            code = (oc == 0) ? 8'h00 : 8'hE1;
            tick(); clear_in();
         end else begin
            code = 8'hE3;
         end
         n_chk++; if (cmd_req !== 4'b0 || rsp_valid !== 1'b1 || rsp_type !== (p.t | 8'h80) || rsp_code !== code) begin
            n_fail++; $display("FAIL rnd_rsp %0d: req %b v %b type %h code %h want 0 1 %h %h",
                               iter, cmd_req, rsp_valid, rsp_type, rsp_code, p.t | 8'h80, code); end
         repeat ($urandom_range(0, 2)) begin
            if (iter < 40 && $urandom_range(0, 2) == 0) begin
               n = rnd_pkt();
               drive(n);
               if (q.size() < 2) q.push_back(n);
               else if (drops < 255) drops++;
            end
            tick(); clear_in();
            n_chk++; if (rsp_valid !== 1'b1 || rsp_code !== code) begin
               n_fail++; $display("FAIL rnd_hold %0d: v %b code %h want 1 %h", iter, rsp_valid, rsp_code, code); end
         end
         rsp_ready = 1'b1; tick(); clear_in();
         n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_ack %0d: v %b want 0", iter, rsp_valid); end
         void'(q.pop_front());
         iter++;
      end
      n_chk++; if (drop_cnt !== 8'(drops)) begin n_fail++; $display("FAIL rnd_drop: got %0d want %0d", drop_cnt, drops); end
   endtask

   task automatic test_async_reset();
      do_reset();
      drive(mk_pkt(8'h01, 8'd4)); tick(); clear_in();
      drive(mk_pkt(8'h02, 8'd4)); pkt_bad = 1'b1; tick(); clear_in();
      drive(mk_pkt(8'h03, 8'd4)); tick(); clear_in();
      n_chk++; if (cmd_req !== 4'b0001 || drop_cnt !== 8'd1 || bad_cnt !== 8'd1) begin
         n_fail++; $display("FAIL arst_pre: req %b drop %0d bad %0d want 0001 1 1", cmd_req, drop_cnt, bad_cnt); end
      #3 rst = 1'b1;
      #1;
      n_chk++; if (cmd_req !== 4'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL arst_now: req %b v %b busy %b want 0 0 0", cmd_req, rsp_valid, busy); end
      n_chk++; if (drop_cnt !== 8'd0 || bad_cnt !== 8'd0 || cmd_len !== 8'd0 || cmd_payload !== '0) begin
         n_fail++; $display("FAIL arst_regs: drop %0d bad %0d len %0d want 0", drop_cnt, bad_cnt, cmd_len); end
      tick();
      rst = 1'b0;
      repeat (3) tick();
      n_chk++; if (cmd_req !== 4'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL arst_pend: req %b busy %b want 0 0", cmd_req, busy); end
   endtask

   initial begin
      test_reset();
      test_known();
      test_unknown();
      test_err_priority();
      test_queue();
      test_back_to_back();
      test_timeout();
      test_bad_cnt();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/rfid_cmd_dispatch.md
# rfid_cmd_dispatch

Command scheduler behind the frame parser. Accepts each parsed packet (type, length, payload), holds at most one queued packet behind the one in service, and dispatches it to one of N_HND command handlers over a req/done handshake. Emits one response descriptor per accepted packet to the transmit framer and keeps saturating drop and bad-frame counters.

## Interface
- MAX_LEN, 32, maximum payload bytes; matches the parser payload bus
- N_HND, 4, number of handlers; type 0x01..N_HND selects handler type-1
- TIMEOUT_CYC, 1000, cycles allowed for handler completion (16-bit range)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- pkt_ready  in  1  one-cycle pulse: valid packet on pkt_type/pkt_len/payload_bus
- pkt_bad  in  1  one-cycle pulse: rejected frame
- pkt_type  in  8  packet type
- pkt_len  in  8  payload length, 1..MAX_LEN
- payload_bus  in  8*MAX_LEN  payload, byte 0 in the MSBs
- cmd_req  out  N_HND  one-hot request, level, held until completion or timeout
- cmd_len  out  8  length of the active command
- cmd_payload  out  8*MAX_LEN  payload of the active command, stable while cmd_req is high
- hnd_done  in  N_HND  per-handler completion pulse
- hnd_err  in  N_HND  per-handler error pulse
- rsp_valid  out  1  response descriptor valid
- rsp_ready  in  1  framer accepts the descriptor
- rsp_type  out  8  response type, pkt_type | 0x80
- rsp_code  out  8  status: 0x00 OK, 0xE1 handler error, 0xE2 timeout, 0xE3 unknown type
- busy  out  1  high when state is not IDLE
- drop_cnt  out  8  saturating count of packets dropped because the queue was full
- bad_cnt  out  8  saturating count of pkt_bad pulses

## Operation
- Reset: every output is 0, state is IDLE, pending slot is empty, counters are 0.
- The pending slot is one entry holding type, len and payload.
- States:
  - IDLE:
    - If the pending slot is valid, promote it to active.
    - Else, if pkt_ready, capture the packet into active.
    - Known type goes to REQ; unknown type (0x00 or >N_HND) goes to RESP with code 0xE3.
  - REQ/WAIT, merged into one state WAIT:
    - cmd_req[type-1]=1 and the timeout counter runs.
    - hnd_err of the selected handler gives code 0xE1.
    - Otherwise hnd_done of the selected handler gives code 0x00.
    - Timeout gives code 0xE2.
    - Any of these moves to RESP.
  - RESP: rsp_valid=1 until rsp_ready is sampled high, then go to IDLE.
- pkt_ready outside IDLE:
  - If the pending slot is empty, store the packet there.
  - Otherwise drop it and increment drop_cnt (saturating at 0xFF).
- pkt_ready in IDLE while the pending slot is valid: the pending packet is promoted and the new packet refills the slot on the same edge. Nothing is dropped.
- Completion signals:
  - hnd_done and hnd_err from non-selected handlers are ignored.
  - If done and err arrive in the same cycle, err wins.
  - done/err arriving after a timeout is ignored.
- pkt_bad increments bad_cnt (saturating) in any state and produces no response.
- rsp_type and rsp_code are stable while rsp_valid is high.

## Timing
- Known type:
  - pkt_ready at edge T in IDLE with the slot empty gives cmd_req, cmd_len and cmd_payload valid at T+1.
  - Selected hnd_done sampled at edge D: cmd_req drops and rsp_valid rises at D+1.
- Unknown type: pkt_ready at T gives rsp_valid at T+1, with no cmd_req.
- Return to IDLE: rsp_ready sampled high at edge R gives state IDLE at R+1. A valid pending slot is dispatched at R+2.
- Back-to-back throughput is 3 cycles per packet minimum with zero-latency handler and framer.
- Timeout: the counter clears on WAIT entry. If the selected done/err has not arrived by the TIMEOUT_CYC-th WAIT cycle, cmd_req drops and rsp_valid rises on the next edge.
- Asynchronous rst mid-transaction: cmd_req and rsp_valid drop immediately, the pending slot is discarded, and counters clear.

## Configuration
- RFID_CMD_TIMEOUT_EN:
  - Defined: the timeout counter is present and code 0xE2 is generated as above.
  - Undefined: no counter is built; WAIT holds indefinitely until the selected done/err, and 0xE2 is never produced.

## Test plan
- Type 0x02, len 3, payload 11 22 33; hnd_done[1] 5 cycles after req -> cmd_req=0b0010 at T+1 with cmd_len=3; then rsp_type=0x82, rsp_code=0x00.
- Type 0x07 -> no cmd_req; rsp_valid at T+1 with rsp_type=0x87, rsp_code=0xE3.
- hnd_done[1] and hnd_err[1] in the same cycle for a type 0x02 command -> rsp_code=0xE1; hnd_done[0] during WAIT on handler 1 -> ignored.
- Three pkt_ready pulses while WAIT is active -> first is pending, next two dropped, drop_cnt=2; after the response completes, the pending packet is dispatched.
- With RFID_CMD_TIMEOUT_EN and TIMEOUT_CYC=8, handler silent -> cmd_req low after 8 cycles, rsp_code=0xE2; a late hnd_done is ignored.
- 300 pkt_bad pulses -> bad_cnt=0xFF; assert rst mid-WAIT -> all outputs 0 immediately.
